// File: rtl/param_entry_ctrl_if.sv
// Arming handshake between the entry controller (master) and the main bottling machine (slave).
// Carries the BCD targets, the one-cycle start request and the lock level.
interface param_entry_ctrl_if;
  logic        lock;
  logic [11:0] tgt_pills;
  logic [7:0]  tgt_bottles;
  logic        start_pulse;

  modport master (input lock, output tgt_pills, output tgt_bottles, output start_pulse);
  modport slave  (output lock, input tgt_pills, input tgt_bottles, input start_pulse);
endinterface

// File: rtl/param_entry_ctrl.sv
// Front-panel key debounce, BCD target entry and start arming for the bottling machine.
// Optional inc auto-repeat is compiled in when AUTO_REPEAT_EN is defined.
module param_entry_ctrl #(
  parameter int DEB_MS    = 20,
  parameter int ACK_TO    = 100,
  parameter int REJ_MS    = 300,
  parameter int RPT_DELAY = 500,
  parameter int RPT_RATE  = 100
) (
  input  logic                clk_1khz,
  input  logic                rst_n,
  input  logic                btn_sel,
  input  logic                btn_inc,
  input  logic                btn_start,
  input  logic                btn_clr,
  param_entry_ctrl_if.master  arm,
  output logic [2:0]          cursor,
  output logic [4:0]          flicker_mask,
  output logic                err,
  output logic                beep_req
);

  localparam int K_SEL   = 0;
  localparam int K_INC   = 1;
  localparam int K_START = 2;
  localparam int K_CLR   = 3;

  localparam int DW   = $clog2(DEB_MS + 1);
  localparam int TMAX = (ACK_TO > REJ_MS) ? ACK_TO : REJ_MS;
  localparam int TW   = $clog2(TMAX + 1);

  localparam logic [DW-1:0] DEB_LAST = DW'(DEB_MS - 1);
  localparam logic [TW-1:0] ACK_LAST = TW'(ACK_TO - 1);
  localparam logic [TW-1:0] REJ_LAST = TW'(REJ_MS - 1);

  typedef enum logic [1:0] {EDIT, ARMED, LOCKED, REJECT} state_t;

  state_t        state, state_d;
  logic [TW-1:0] timer, timer_d;
  logic [2:0]    cursor_d;
  logic [3:0]    digits   [5];
  logic [3:0]    digits_d [5];
  logic [4:0]    flicker_d;
  logic          start_d, err_d, beep_d;

  logic [3:0]    keys, sync1, sync2, key_lvl, press;
  logic [DW-1:0] deb_cnt [4];
  logic          ev_inc;
  logic          pills_zero, bottles_zero;

  assign keys = {btn_clr, btn_start, btn_inc, btn_sel};

  // Debounced level follows the synchronized key only after DEB_MS stable mismatching cycles.
  always_ff @(posedge clk_1khz or negedge rst_n) begin
    if (!rst_n) begin
      sync1   <= '0;
      sync2   <= '0;
      key_lvl <= '0;
      press   <= '0;
      for (int i = 0; i < 4; i++) deb_cnt[i] <= '0;
    end else begin
      sync1 <= keys;
      sync2 <= sync1;
      for (int i = 0; i < 4; i++) begin
        press[i] <= 1'b0;
        if (sync2[i] == key_lvl[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DEB_LAST) begin
          deb_cnt[i] <= '0;
          key_lvl[i] <= sync2[i];
          press[i]   <= sync2[i];
        end else begin
          deb_cnt[i] <= deb_cnt[i] + 1'b1;
        end
      end
    end
  end

`ifdef AUTO_REPEAT_EN
  localparam int RMAX = (RPT_DELAY > RPT_RATE) ? RPT_DELAY : RPT_RATE;
  localparam int RW   = $clog2(RMAX + 1);
  localparam logic [RW-1:0] DLY_LAST  = RW'(RPT_DELAY - 1);
  localparam logic [RW-1:0] RATE_LAST = RW'(RPT_RATE - 1);

  logic          rpt_active, rpt_active_d;
  logic          rpt_first, rpt_first_d;
  logic [RW-1:0] rpt_cnt, rpt_cnt_d;
  logic          rpt_fire;

  assign rpt_fire = rpt_active && key_lvl[K_INC] && (state == EDIT) &&
                    (rpt_cnt == (rpt_first ? DLY_LAST : RATE_LAST));
  assign ev_inc   = press[K_INC] | rpt_fire;

  // Repeat timer restarts on every acted inc; anything that leaves EDIT or outranks inc cancels it.
  always_comb begin
    rpt_active_d = 1'b0;
    rpt_cnt_d    = '0;
    rpt_first_d  = rpt_first;
    if ((state == EDIT) && (state_d == EDIT) && key_lvl[K_INC] &&
        !press[K_CLR] && !press[K_START]) begin
      if (ev_inc) begin
        rpt_active_d = 1'b1;
        rpt_first_d  = press[K_INC];
      end else if (rpt_active) begin
        rpt_active_d = 1'b1;
        rpt_cnt_d    = rpt_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_1khz or negedge rst_n) begin
    if (!rst_n) begin
      rpt_active <= 1'b0;
      rpt_first  <= 1'b0;
      rpt_cnt    <= '0;
    end else begin
      rpt_active <= rpt_active_d;
      rpt_first  <= rpt_first_d;
      rpt_cnt    <= rpt_cnt_d;
    end
  end
`else
  logic unused_rpt;
  assign unused_rpt = ^{32'(RPT_DELAY), 32'(RPT_RATE)};
  assign ev_inc     = press[K_INC];
`endif

  assign pills_zero   = (digits[0] == 4'd0) && (digits[1] == 4'd0) && (digits[2] == 4'd0);
  assign bottles_zero = (digits[3] == 4'd0) && (digits[4] == 4'd0);

  // Next state and next register values; only the highest-priority event in EDIT is acted on.
  always_comb begin
    state_d  = state;
    timer_d  = timer;
    cursor_d = cursor;
    digits_d = digits;
    start_d  = 1'b0;
    err_d    = 1'b0;
    beep_d   = 1'b0;
    case (state)
      EDIT: begin
        if (arm.lock) begin
          state_d = LOCKED;
        end else if (press[K_CLR]) begin
          for (int i = 0; i < 5; i++) digits_d[i] = 4'd0;
          cursor_d = 3'd0;
          beep_d   = 1'b1;
        end else if (press[K_START]) begin
          beep_d  = 1'b1;
          timer_d = '0;
          if (pills_zero || bottles_zero) begin
            state_d = REJECT;
            err_d   = 1'b1;
          end else begin
            state_d = ARMED;
            start_d = 1'b1;
          end
        end else if (ev_inc) begin
          digits_d[cursor] = (digits[cursor] >= 4'd9) ? 4'd0 : digits[cursor] + 4'd1;
          beep_d = 1'b1;
        end else if (press[K_SEL]) begin
          cursor_d = (cursor == 3'd4) ? 3'd0 : cursor + 3'd1;
          beep_d   = 1'b1;
        end
      end
      ARMED: begin
        if (arm.lock) begin
          state_d = LOCKED;
        end else if (timer == ACK_LAST) begin
          state_d = EDIT;
          err_d   = 1'b1;
        end else begin
          timer_d = timer + 1'b1;
        end
      end
      LOCKED: begin
        if (!arm.lock) state_d = EDIT;
      end
      REJECT: begin
        if (timer == REJ_LAST) begin
          state_d = EDIT;
        end else begin
          timer_d = timer + 1'b1;
          err_d   = 1'b1;
        end
      end
      default: state_d = EDIT;
    endcase
    flicker_d = (state_d == EDIT) ? (5'b00001 << cursor_d) : 5'b00000;
  end

  always_ff @(posedge clk_1khz or negedge rst_n) begin
    if (!rst_n) begin
      state           <= EDIT;
      timer           <= '0;
      cursor          <= 3'd0;
      for (int i = 0; i < 5; i++) digits[i] <= 4'd0;
      flicker_mask    <= 5'b00001;
      arm.start_pulse <= 1'b0;
      err             <= 1'b0;
      beep_req        <= 1'b0;
    end else begin
      state           <= state_d;
      timer           <= timer_d;
      cursor          <= cursor_d;
      digits          <= digits_d;
      flicker_mask    <= flicker_d;
      arm.start_pulse <= start_d;
      err             <= err_d;
      beep_req        <= beep_d;
    end
  end

  assign arm.tgt_pills   = {digits[0], digits[1], digits[2]};
  assign arm.tgt_bottles = {digits[3], digits[4]};

endmodule

// File: tb/tb_param_entry_ctrl.sv
// Directed plus randomized bench for param_entry_ctrl against a decimal-valued reference model.
// Define AUTO_REPEAT_EN to also exercise the inc auto-repeat.
module tb_param_entry_ctrl;

  localparam int DEB_MS    = 20;
  localparam int ACK_TO    = 100;
  localparam int REJ_MS    = 300;
  localparam int RPT_DELAY = 500;
  localparam int RPT_RATE  = 100;
  localparam int HOLD      = DEB_MS + 10;

  logic       clk_1khz = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn_sel = 1'b0, btn_inc = 1'b0, btn_start = 1'b0, btn_clr = 1'b0;
  logic [2:0] cursor;
  logic [4:0] flicker_mask;
  logic       err, beep_req;

  param_entry_ctrl_if bus ();

  param_entry_ctrl #(
    .DEB_MS(DEB_MS), .ACK_TO(ACK_TO), .REJ_MS(REJ_MS),
    .RPT_DELAY(RPT_DELAY), .RPT_RATE(RPT_RATE)
  ) dut (
    .clk_1khz(clk_1khz), .rst_n(rst_n),
    .btn_sel(btn_sel), .btn_inc(btn_inc), .btn_start(btn_start), .btn_clr(btn_clr),
    .arm(bus), .cursor(cursor), .flicker_mask(flicker_mask),
    .err(err), .beep_req(beep_req)
  );

  always #5 clk_1khz = ~clk_1khz;

  int checks = 0;
  int errors = 0;
  int beep_cnt = 0, start_cnt = 0, err_cycles = 0;
  int m_pills = 0, m_bottles = 0, m_cursor = 0;

  always @(negedge clk_1khz) begin
    if (rst_n) begin
      if (beep_req) beep_cnt++;
      if (bus.start_pulse) start_cnt++;
      if (err) err_cycles++;
    end
  end

  task automatic check_output(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Model works on plain decimal values; a digit is isolated by its decimal weight.
  function automatic int bump(input int v, input int w);
    int d;
    d = (v / w) % 10;
    return v - d * w + ((d + 1) % 10) * w;
  endfunction

  function automatic int weight(input int pos);
    case (pos)
      0: return 100;
      1, 3: return 10;
      default: return 1;
    endcase
  endfunction

  function automatic int digit_at(input int pos);
    return (pos < 3) ? (m_pills / weight(pos)) % 10 : (m_bottles / weight(pos)) % 10;
  endfunction

  function automatic int bcd(input int v);
    return ((v / 100) << 8) | (((v / 10) % 10) << 4) | (v % 10);
  endfunction

  task automatic model_key(input int key);
    case (key)
      0: m_cursor = (m_cursor + 1) % 5;
      1: if (m_cursor < 3) m_pills = bump(m_pills, weight(m_cursor));
         else m_bottles = bump(m_bottles, weight(m_cursor));
      3: begin m_pills = 0; m_bottles = 0; m_cursor = 0; end
      default: ;
    endcase
  endtask

  task automatic check_model(input string tag);
    check_output({tag, "_pills"}, int'(bus.tgt_pills), bcd(m_pills));
    check_output({tag, "_bottles"}, int'(bus.tgt_bottles), bcd(m_bottles));
    check_output({tag, "_cursor"}, int'(cursor), m_cursor);
    check_output({tag, "_flicker"}, int'(flicker_mask), 1 << m_cursor);
  endtask

  // key: 0 sel, 1 inc, 2 start, 3 clr
  task automatic apply_stimulus(input int key);
    @(negedge clk_1khz);
    case (key)
      0: btn_sel = 1'b1;
      1: btn_inc = 1'b1;
      2: btn_start = 1'b1;
      default: btn_clr = 1'b1;
    endcase
    repeat (HOLD) @(negedge clk_1khz);
    btn_sel = 1'b0; btn_inc = 1'b0; btn_start = 1'b0; btn_clr = 1'b0;
    repeat (HOLD) @(negedge clk_1khz);
  endtask

  task automatic press_modelled(input int key, input string tag);
    int b0;
    b0 = beep_cnt;
    apply_stimulus(key);
    model_key(key);
    check_output({tag, "_beep"}, beep_cnt - b0, 1);
  endtask

  task automatic set_targets(input int p, input int b);
    int want;
    press_modelled(3, "set_clr");
    for (int pos = 0; pos < 5; pos++) begin
      want = (pos < 3) ? (p / weight(pos)) % 10 : (b / weight(pos)) % 10;
      while (digit_at(pos) != want) press_modelled(1, "set_inc");
      press_modelled(0, "set_sel");
    end
  endtask

  task automatic wait_start(output int seen);
    seen = 0;
    for (int i = 0; i < 100 && seen == 0; i++) begin
      @(negedge clk_1khz);
      if (bus.start_pulse) seen = 1;
    end
  endtask

  initial begin
    int b0, s0, e0, seen, n, key;
    bus.lock = 1'b0;

    repeat (3) @(negedge clk_1khz);
    check_output("rst_in_pills", int'(bus.tgt_pills), 0);
    check_output("rst_in_flicker", int'(flicker_mask), 5'b00001);
    rst_n = 1'b1;
    repeat (2) @(negedge clk_1khz);
    check_model("reset");
    check_output("reset_start", int'(bus.start_pulse), 0);
    check_output("reset_err", int'(err), 0);
    check_output("reset_beep", int'(beep_req), 0);

    // Cursor 1 is the pills tens digit: 13 increments leave 3 with no carry.
    press_modelled(0, "entry_sel");
    for (int i = 0; i < 13; i++) press_modelled(1, "entry_inc");
    check_output("entry_030", int'(bus.tgt_pills), 12'h030);
    check_model("entry");

    b0 = beep_cnt;
    for (int i = 0; i < 20; i++) begin
      btn_inc = (i % 2 == 0);
      repeat (5) @(negedge clk_1khz);
    end
    btn_inc = 1'b1;
    repeat (HOLD) @(negedge clk_1khz);
    btn_inc = 1'b0;
    repeat (HOLD) @(negedge clk_1khz);
    model_key(1);
    check_output("bounce_beep", beep_cnt - b0, 1);
    check_model("bounce");

    for (int i = 0; i < 30; i++) begin
      key = $urandom_range(0, 9);
      key = (key < 4) ? 0 : (key < 9) ? 1 : 3;
      press_modelled(key, "rand");
      check_model("rand");
    end

    set_targets(123, 0);
    b0 = beep_cnt; s0 = start_cnt; e0 = err_cycles;
    apply_stimulus(2);
    apply_stimulus(0);
    repeat (REJ_MS) @(negedge clk_1khz);
    check_output("rej_start", start_cnt - s0, 0);
    check_output("rej_err_len", err_cycles - e0, REJ_MS);
    check_output("rej_beep", beep_cnt - b0, 1);
    check_model("rej");

    set_targets(120, 5);
    b0 = beep_cnt; s0 = start_cnt; e0 = err_cycles;
    btn_start = 1'b1;
    wait_start(seen);
    check_output("arm_start_seen", seen, 1);
    repeat (3) @(negedge clk_1khz);
    bus.lock = 1'b1;
    repeat (2) @(negedge clk_1khz);
    check_output("lock_flicker", int'(flicker_mask), 0);
    btn_start = 1'b0;
    repeat (HOLD) @(negedge clk_1khz);
    apply_stimulus(3);
    check_output("lock_pills", int'(bus.tgt_pills), 12'h120);
    check_output("lock_bottles", int'(bus.tgt_bottles), 8'h05);
    check_output("lock_start_cnt", start_cnt - s0, 1);
    check_output("lock_err", err_cycles - e0, 0);
    check_output("lock_beep", beep_cnt - b0, 1);
    bus.lock = 1'b0;
    repeat (3) @(negedge clk_1khz);
    check_model("unlock");

    b0 = beep_cnt; e0 = err_cycles;
    btn_start = 1'b1;
    wait_start(seen);
    check_output("ack_start_seen", seen, 1);
    n = 0;
    for (int i = 1; i <= 150 && n == 0; i++) begin
      @(negedge clk_1khz);
      if (err) n = i;
    end
    check_output("ack_err_delay", n, ACK_TO);
    btn_start = 1'b0;
    repeat (HOLD) @(negedge clk_1khz);
    check_output("ack_err_len", err_cycles - e0, 1);
    check_output("ack_beep", beep_cnt - b0, 1);
    check_model("ack");

    btn_start = 1'b1;
    wait_start(seen);
    check_output("rstmid_start_seen", seen, 1);
    rst_n = 1'b0;
    #1;
    m_pills = 0; m_bottles = 0; m_cursor = 0;
    check_output("rstmid_start", int'(bus.start_pulse), 0);
    check_output("rstmid_err", int'(err), 0);
    check_model("rstmid");
    btn_start = 1'b0;
    repeat (HOLD) @(negedge clk_1khz);
    rst_n = 1'b1;
    repeat (HOLD) @(negedge clk_1khz);
    check_model("rstmid_after");

`ifdef AUTO_REPEAT_EN
    // Press event plus repeats at +500, +600, +700 within a 750-cycle hold.
    b0 = beep_cnt;
    btn_inc = 1'b1;
    seen = 0;
    for (int i = 0; i < 100 && seen == 0; i++) begin
      @(negedge clk_1khz);
      if (beep_req) seen = 1;
    end
    check_output("rpt_first_seen", seen, 1);
    repeat (750) @(negedge clk_1khz);
    btn_inc = 1'b0;
    repeat (HOLD) @(negedge clk_1khz);
    for (int i = 0; i < 4; i++) model_key(1);
    check_output("rpt_beeps", beep_cnt - b0, 4);
    check_model("rpt");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
